// File: rtl/cmd_proc.sv
// -----------------------------------------------------------------------------
// cmd_proc
//
// Command processor sitting behind the UART command wrapper. It accepts one
// 16-bit command at a time, launches calibration / heading / move / solve,
// waits for the matching completion under a watchdog, then hands a one-byte
// response back to the wrapper and waits for it to be transmitted before it
// will accept the next command.
//
// Ports
//   clk              system clock, rising edge
//   rst              synchronous active-high reset
//   cmd_rdy, cmd     command handshake from the wrapper ([15:13] op, [12:0] arg)
//   clr_cmd_rdy      one-cycle pulse when the command is consumed
//   cal_done         calibration complete
//   mv_cmplt         heading change or move complete
//   sol_cmplt        maze solve complete
//   strt_cal         one-cycle calibration launch
//   strt_hdng        one-cycle heading launch
//   strt_mv          one-cycle move launch
//   desired_heading  heading target latched from cmd[11:0]
//   stp_lft/stp_rght move stop conditions latched from cmd[1]/cmd[0]
//   cmd_md           1 = host command mode, 0 = autonomous solve running
//   in_cal           high while calibration is running
//   send_resp, resp  response strobe and byte toward the wrapper transmitter
//   tx_done          wrapper has finished sending resp
//
// state     | meaning
// ----------+-----------------------------------------------------------------
// IDLE      | ready; a pending cmd_rdy is consumed and launched this cycle
// WAIT_CAL  | calibration running, waiting for cal_done or watchdog
// WAIT_HDNG | heading change running, waiting for mv_cmplt or watchdog
// WAIT_MV   | move running, waiting for mv_cmplt or watchdog
// WAIT_SOL  | solve running, waiting for sol_cmplt or watchdog
// RESP      | send_resp high for this single cycle
// WAIT_TX   | response byte in flight, waiting for tx_done
// -----------------------------------------------------------------------------
module cmd_proc #(
    parameter int unsigned        TO_W    = 24,
    parameter logic [TO_W-1:0]    TIMEOUT = 24'hFF_FFFF,
    parameter logic [7:0]         ACK     = 8'hA5,
    parameter logic [7:0]         ERR_TO  = 8'hEE,
    parameter logic [7:0]         ERR_OP  = 8'hE0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_rdy,
    input  logic [15:0] cmd,
    output logic        clr_cmd_rdy,
    input  logic        cal_done,
    input  logic        mv_cmplt,
    input  logic        sol_cmplt,
    output logic        strt_cal,
    output logic        strt_hdng,
    output logic        strt_mv,
    output logic [11:0] desired_heading,
    output logic        stp_lft,
    output logic        stp_rght,
    output logic        cmd_md,
    output logic        in_cal,
    output logic        send_resp,
    output logic [7:0]  resp,
    input  logic        tx_done
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_CAL  = 3'd1,
        WAIT_HDNG = 3'd2,
        WAIT_MV   = 3'd3,
        WAIT_SOL  = 3'd4,
        RESP      = 3'd5,
        WAIT_TX   = 3'd6
    } state_t;

    localparam logic [2:0] OP_CAL  = 3'b000;
    localparam logic [2:0] OP_HDNG = 3'b001;
    localparam logic [2:0] OP_MV   = 3'b010;
    localparam logic [2:0] OP_SOL  = 3'b011;

    state_t            state;
    logic [TO_W-1:0]   wdog;
    logic [2:0]        opcode;
    logic              accept;
    logic              done_sel;
    logic              timed_out;
    logic              unused_cmd_bit;

    assign opcode = cmd[15:13];

    // Operand bit 12 has no meaning for any opcode.
    assign unused_cmd_bit = cmd[12];

    // The wrapper expects the consume pulse in the same cycle it presents
    // cmd_rdy, and launches must coincide with it, so these strobes are
    // decoded from the current state rather than registered. Gating with rst
    // keeps a command that is pending during reset from being swallowed.
    assign accept      = (state == IDLE) && cmd_rdy && !rst;
    assign clr_cmd_rdy = accept;
    assign strt_cal    = accept && (opcode == OP_CAL);
    assign strt_hdng   = accept && (opcode == OP_HDNG);
    assign strt_mv     = accept && (opcode == OP_MV);

    // Only the completion that belongs to the current wait state counts.
    always_comb begin
        done_sel = 1'b0;
        unique case (state)
            WAIT_CAL:  done_sel = cal_done;
            WAIT_HDNG: done_sel = mv_cmplt;
            WAIT_MV:   done_sel = mv_cmplt;
            WAIT_SOL:  done_sel = sol_cmplt;
            default:   done_sel = 1'b0;
        endcase
    end

    assign timed_out = (wdog == TIMEOUT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            wdog            <= '0;
            desired_heading <= 12'h000;
            stp_lft         <= 1'b0;
            stp_rght        <= 1'b0;
            cmd_md          <= 1'b1;
            in_cal          <= 1'b0;
            resp            <= 8'h00;
            send_resp       <= 1'b0;
        end else begin
            send_resp <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cmd_rdy) begin
                        wdog <= '0;
                        unique case (opcode)
                            OP_CAL: begin
                                in_cal <= 1'b1;
                                state  <= WAIT_CAL;
                            end
                            OP_HDNG: begin
                                desired_heading <= cmd[11:0];
                                state           <= WAIT_HDNG;
                            end
                            OP_MV: begin
                                stp_lft  <= cmd[1];
                                stp_rght <= cmd[0];
                                state    <= WAIT_MV;
                            end
                            OP_SOL: begin
                                cmd_md <= 1'b0;
                                state  <= WAIT_SOL;
                            end
                            default: begin
                                resp      <= ERR_OP;
                                send_resp <= 1'b1;
                                state     <= RESP;
                            end
                        endcase
                    end
                end

                WAIT_CAL, WAIT_HDNG, WAIT_MV, WAIT_SOL: begin
                    // Saturating count; the compare below leaves the state
                    // on the same cycle the terminal value is seen.
                    if (!timed_out) begin
                        wdog <= wdog + 1'b1;
                    end
                    if (done_sel || timed_out) begin
                        // Completion takes priority over a coincident timeout.
                        resp <= done_sel ? ACK : ERR_TO;
                        if (state == WAIT_CAL) begin
                            in_cal <= 1'b0;
                        end
                        if (state == WAIT_SOL) begin
                            cmd_md <= 1'b1;
                        end
                        send_resp <= 1'b1;
                        state     <= RESP;
                    end
                end

                RESP: begin
                    state <= WAIT_TX;
                end

                WAIT_TX: begin
                    if (tx_done) begin
                        state <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_proc.sv
// -----------------------------------------------------------------------------
// tb_cmd_proc
//
// Drives cmd_proc with directed and randomized commands on an absolute cycle
// plan. Expected accepts and responses are queued when each command is issued;
// a negedge monitor pops them whenever the DUT strobes clr_cmd_rdy/strt_* or
// send_resp and compares cycle, strobes and output values.
// -----------------------------------------------------------------------------
module tb_cmd_proc;

    localparam int          TO_CYC  = 100;
    localparam logic [23:0] TO_VAL  = 24'd100;
    localparam logic [7:0]  R_ACK   = 8'hA5;
    localparam logic [7:0]  R_TO    = 8'hEE;
    localparam logic [7:0]  R_OP    = 8'hE0;
    localparam int          OC_NORM = 0;
    localparam int          OC_TO   = 1;
    localparam int          OC_EDGE = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_rdy;
    logic [15:0] cmd;
    logic        clr_cmd_rdy;
    logic        cal_done, mv_cmplt, sol_cmplt;
    logic        strt_cal, strt_hdng, strt_mv;
    logic [11:0] desired_heading;
    logic        stp_lft, stp_rght, cmd_md, in_cal;
    logic        send_resp;
    logic [7:0]  resp;
    logic        tx_done;

    cmd_proc #(.TO_W(24), .TIMEOUT(TO_VAL)) dut (
        .clk(clk), .rst(rst), .cmd_rdy(cmd_rdy), .cmd(cmd),
        .clr_cmd_rdy(clr_cmd_rdy), .cal_done(cal_done), .mv_cmplt(mv_cmplt),
        .sol_cmplt(sol_cmplt), .strt_cal(strt_cal), .strt_hdng(strt_hdng),
        .strt_mv(strt_mv), .desired_heading(desired_heading), .stp_lft(stp_lft),
        .stp_rght(stp_rght), .cmd_md(cmd_md), .in_cal(in_cal),
        .send_resp(send_resp), .resp(resp), .tx_done(tx_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [2:0] op;
    } acc_t;

    typedef struct {
        int          cyc;
        logic [7:0]  resp;
        logic [11:0] head;
        logic        lft;
        logic        rght;
    } rsp_t;

    acc_t acc_q[$];
    rsp_t rsp_q[$];
    acc_t ma;
    rsp_t mr;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model of the latched command fields
    logic [11:0] m_head = 12'h000;
    logic        m_lft  = 1'b0;
    logic        m_rght = 1'b0;

    bit          raised = 1'b0;
    logic [15:0] next_cmd;

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %b, expected %b", name, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int n);
        while (cyc < n) step();
    endtask

    function automatic logic [15:0] rand_cmd();
        logic [15:0] v;
        v = 16'($urandom);
        if ($urandom_range(0, 3) != 0) v[15:13] = 3'($urandom_range(0, 3));
        else                           v[15:13] = 3'($urandom_range(4, 7));
        return v;
    endfunction

    task automatic model_accept(input logic [15:0] c);
        if (c[15:13] == 3'd1) m_head = c[11:0];
        if (c[15:13] == 3'd2) begin
            m_lft  = c[1];
            m_rght = c[0];
        end
    endtask

    // One full command: accept, optional completion, response, tx_done.
    // With early set, the next command is presented from two cycles after
    // acceptance and held until the DUT is idle again.
    task automatic txn(input logic [15:0] c, input int outcome, input int dly,
                       input int txd, input bit early, input logic [15:0] nxt);
        int a, comp, rc, tc;
        bit has_comp;
        logic [2:0] op;
        acc_t ai;
        rsp_t ri;
        op = c[15:13];
        if (!raised) begin
            step();
            cmd     = c;
            cmd_rdy = 1'b1;
        end
        a      = cyc;
        ai.cyc = a;
        ai.op  = op;
        acc_q.push_back(ai);
        model_accept(c);
        has_comp = 1'b0;
        comp     = 0;
        if (op > 3'd3) begin
            rc      = a + 1;
            ri.resp = R_OP;
        end else if (outcome == OC_TO) begin
            rc      = a + TO_CYC + 2;
            ri.resp = R_TO;
        end else begin
            comp     = (outcome == OC_EDGE) ? a + TO_CYC + 1 : a + dly;
            has_comp = 1'b1;
            rc       = comp + 1;
            ri.resp  = R_ACK;
        end
        ri.cyc  = rc;
        ri.head = m_head;
        ri.lft  = m_lft;
        ri.rght = m_rght;
        rsp_q.push_back(ri);
        tc = rc + txd;
        for (int k = a + 1; k <= tc; k++) begin
            wait_until(k);
            cal_done  = 1'b0;
            mv_cmplt  = 1'b0;
            sol_cmplt = 1'b0;
            tx_done   = (k == tc);
            if (k == a + 1) begin
                // hold cmd_rdy one more cycle and pulse the non-matching completions
                cmd_rdy   = 1'b1;
                cal_done  = (op != 3'd0);
                mv_cmplt  = !(op == 3'd1 || op == 3'd2);
                sol_cmplt = (op != 3'd3);
            end else if (early) begin
                cmd_rdy = 1'b1;
                cmd     = nxt;
            end else begin
                cmd_rdy = 1'b0;
            end
            if (has_comp && k == comp) begin
                case (op)
                    3'd0:    cal_done  = 1'b1;
                    3'd3:    sol_cmplt = 1'b1;
                    default: mv_cmplt  = 1'b1;
                endcase
            end
            if (k == a + 1) begin
                @(negedge clk);
                check_bit("in_cal_running", in_cal, op == 3'd0);
                check_bit("cmd_md_running", cmd_md, op != 3'd3);
            end
            if (k == tc) begin
                @(negedge clk);
                check_val("resp_hold", 32'(resp), 32'(ri.resp));
            end
        end
        step();
        cal_done  = 1'b0;
        mv_cmplt  = 1'b0;
        sol_cmplt = 1'b0;
        tx_done   = 1'b0;
        raised    = early;
    endtask

    // Accept a command, then reset off cycles later; no response may follow.
    task automatic abort_txn(input logic [15:0] c, input int off);
        int a;
        acc_t ai;
        rsp_t ri;
        step();
        cmd     = c;
        cmd_rdy = 1'b1;
        a       = cyc;
        ai.cyc  = a;
        ai.op   = c[15:13];
        acc_q.push_back(ai);
        model_accept(c);
        if (c[15:13] > 3'd3) begin
            ri.cyc  = a + 1;
            ri.resp = R_OP;
            ri.head = m_head;
            ri.lft  = m_lft;
            ri.rght = m_rght;
            rsp_q.push_back(ri);
        end
        step();
        cmd_rdy = 1'b0;
        wait_until(a + off);
        rst = 1'b1;
        step();
        rst    = 1'b0;
        m_head = 12'h000;
        m_lft  = 1'b0;
        m_rght = 1'b0;
        @(negedge clk);
        check_bit("abort_in_cal", in_cal, 1'b0);
        check_bit("abort_cmd_md", cmd_md, 1'b1);
        check_val("abort_resp", 32'(resp), 32'h00);
        check_val("abort_heading", 32'(desired_heading), 32'h000);
    endtask

    task automatic run_random(input int n);
        logic [15:0] c;
        bit early;
        int oc;
        for (int i = 0; i < n; i++) begin
            c        = next_cmd;
            next_cmd = rand_cmd();
            early    = (i < n - 1) && ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 5))
                0:       oc = OC_TO;
                1:       oc = OC_EDGE;
                default: oc = OC_NORM;
            endcase
            if (!raised) repeat ($urandom_range(0, 2)) step();
            txn(c, oc, $urandom_range(1, 40), $urandom_range(1, 20), early, next_cmd);
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (cyc >= 1) begin
            if (clr_cmd_rdy === 1'b1 || strt_cal === 1'b1 ||
                strt_hdng === 1'b1 || strt_mv === 1'b1) begin
                if (acc_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_accept at cycle %0d: clr=%b cal=%b hdng=%b mv=%b, expected none",
                             cyc, clr_cmd_rdy, strt_cal, strt_hdng, strt_mv);
                end else begin
                    ma = acc_q.pop_front();
                    check_val("accept_cycle", cyc, ma.cyc);
                    check_bit("clr_cmd_rdy", clr_cmd_rdy, 1'b1);
                    check_bit("strt_cal", strt_cal, ma.op == 3'd0);
                    check_bit("strt_hdng", strt_hdng, ma.op == 3'd1);
                    check_bit("strt_mv", strt_mv, ma.op == 3'd2);
                end
            end
            if (send_resp === 1'b1) begin
                if (rsp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_send_resp at cycle %0d: resp=%0h, expected no response", cyc, resp);
                end else begin
                    mr = rsp_q.pop_front();
                    check_val("resp_cycle", cyc, mr.cyc);
                    check_val("resp_byte", 32'(resp), 32'(mr.resp));
                    check_val("desired_heading", 32'(desired_heading), 32'(mr.head));
                    check_bit("stp_lft", stp_lft, mr.lft);
                    check_bit("stp_rght", stp_rght, mr.rght);
                    check_bit("in_cal_at_resp", in_cal, 1'b0);
                    check_bit("cmd_md_at_resp", cmd_md, 1'b1);
                end
            end
        end
    end

    initial begin
        #5_000_000;
        n_fail++;
        $display("FAIL global_timeout: simulation still running at %0t, expected to have finished", $time);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "time limit");
    end

    initial begin
        rst       = 1'b1;
        cmd_rdy   = 1'b1;
        cmd       = 16'h23FF;
        cal_done  = 1'b0;
        mv_cmplt  = 1'b0;
        sol_cmplt = 1'b0;
        tx_done   = 1'b0;

        // two reset edges with a command already pending
        step();
        @(negedge clk);
        check_bit("rst_clr_cmd_rdy", clr_cmd_rdy, 1'b0);
        check_bit("rst_send_resp", send_resp, 1'b0);
        check_val("rst_heading", 32'(desired_heading), 32'h000);
        check_bit("rst_stp_lft", stp_lft, 1'b0);
        check_bit("rst_stp_rght", stp_rght, 1'b0);
        check_bit("rst_cmd_md", cmd_md, 1'b1);
        check_bit("rst_in_cal", in_cal, 1'b0);
        check_val("rst_resp", 32'(resp), 32'h00);
        step();
        rst    = 1'b0;
        raised = 1'b1;

        // directed sequence; the pending heading command is taken first
        txn(16'h23FF, OC_NORM, 50, 20, 1'b0, 16'h0000);
        txn(16'h4002, OC_NORM, 30, 10, 1'b1, 16'h0000);
        txn(16'h0000, OC_TO,    0,  5, 1'b0, 16'h0000);
        txn(16'h6000, OC_NORM, 25,  3, 1'b0, 16'h0000);
        txn(16'h6000, OC_EDGE,  0,  4, 1'b0, 16'h0000);
        txn(16'h2ABC, OC_NORM,  1,  1, 1'b0, 16'h0000);
        txn(16'hE123, OC_NORM,  0,  6, 1'b0, 16'h0000);

        next_cmd = rand_cmd();
        run_random(25);

        abort_txn(16'hE123, 3);
        abort_txn(16'h0000, 3);
        abort_txn(16'h6000, 5);

        next_cmd = rand_cmd();
        run_random(6);

        repeat (5) step();
        check_val("accept_queue_drained", acc_q.size(), 0);
        check_val("response_queue_drained", rsp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cmd_proc.md
Name: cmd_proc

Overview:
- Command processor directly downstream of the UART command wrapper. Consumes the 16-bit cmd/cmd_rdy pair and pulses clr_cmd_rdy on acceptance.
- Decodes the opcode, launches calibration, heading, move or solve, and waits for completion with a watchdog.
- On completion or failure, hands a one-byte response back to the wrapper's transmit side (resp/send_resp) and waits for tx_done before accepting the next command.

Parameters:
TO_W, 24, width of watchdog counter; timeout fires when counter reaches TIMEOUT
TIMEOUT, 24'hFF_FFFF, cycles allowed in any WAIT state before error response
ACK, 8'hA5, response byte for successful completion
ERR_TO, 8'hEE, response byte for watchdog timeout
ERR_OP, 8'hE0, response byte for illegal opcode

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
cmd_rdy  in  1  16-bit command available from UART wrapper
cmd  in  16  command word: [15:13] opcode, [12:0] operand
clr_cmd_rdy  out  1  one-cycle pulse: command consumed
cal_done  in  1  calibration finished (pulse or level)
mv_cmplt  in  1  heading/move finished
sol_cmplt  in  1  maze solve finished
strt_cal  out  1  one-cycle pulse: start calibration
strt_hdng  out  1  one-cycle pulse: start heading change
strt_mv  out  1  one-cycle pulse: start move
desired_heading  out  12  heading target, latched from cmd[11:0]
stp_lft  out  1  move stops at left opening, latched from cmd[1]
stp_rght  out  1  move stops at right opening, latched from cmd[0]
cmd_md  out  1  1 = host command mode, 0 = autonomous solve
in_cal  out  1  high while calibration in progress
send_resp  out  1  one-cycle pulse to wrapper trmt
resp  out  8  response byte, stable from send_resp until tx_done
tx_done  in  1  wrapper finished transmitting resp

Behaviour:
- Reset values:
  - All strobes (clr_cmd_rdy, strt_*, send_resp) = 0.
  - desired_heading = 12'h000; stp_lft = stp_rght = 0.
  - cmd_md = 1; in_cal = 0; resp = 8'h00.
  - State = IDLE; watchdog = 0.
- Reset mid-operation aborts any WAIT/RESP state immediately. No response is sent for the aborted command.
- States: IDLE, WAIT_CAL, WAIT_HDNG, WAIT_MV, WAIT_SOL, RESP, WAIT_TX.
- IDLE, cmd_rdy=1: clr_cmd_rdy=1 in the same cycle. Decode cmd[15:13]; launch strobes assert in that same cycle.
  - 3'b000: strt_cal=1, in_cal<=1, go WAIT_CAL.
  - 3'b001: desired_heading<=cmd[11:0], strt_hdng=1, go WAIT_HDNG.
  - 3'b010: stp_lft<=cmd[1], stp_rght<=cmd[0], strt_mv=1, go WAIT_MV.
  - 3'b011: cmd_md<=0, go WAIT_SOL.
  - any other opcode: resp<=ERR_OP, go RESP.
- Any WAIT state:
  - Watchdog clears on entry and increments every cycle.
  - Completion input high: resp<=ACK, go RESP. Exit actions on completion:
    - WAIT_CAL clears in_cal.
    - WAIT_SOL sets cmd_md<=1.
  - Watchdog == TIMEOUT with completion low: resp<=ERR_TO, same exit actions, go RESP.
  - Completion and timeout in the same cycle: completion wins (ACK).
- RESP: send_resp=1 for exactly one cycle, then WAIT_TX.
- WAIT_TX: tx_done=1 → IDLE. resp holds its value until the next response is loaded.
- Busy behaviour:
  - A cmd_rdy arriving in any non-IDLE state is not consumed (no clr_cmd_rdy); it is accepted on return to IDLE.
  - Completion inputs arriving outside their matching WAIT state are ignored.
- Latency:
  - Accept to launch strobe: 0 cycles.
  - Completion to send_resp: 1 cycle.
  - tx_done to next accept: 1 cycle.
- Watchdog saturates at TIMEOUT and never wraps.
- clr_cmd_rdy is never asserted in consecutive cycles.

Test Plan:
- Reset with rst=1 for 2 cycles while cmd_rdy=1 → all outputs at reset values, no clr_cmd_rdy until the first cycle after rst drops.
- Heading: cmd=16'h2_3FF (op 001, 12'h3FF), mv_cmplt pulse 50 cycles later, tx_done 20 cycles after send_resp:
  - clr_cmd_rdy and strt_hdng pulse in the same cycle; desired_heading=12'h3FF.
  - send_resp 1 cycle after mv_cmplt, resp=8'hA5; IDLE after tx_done.
- Move: cmd=16'h4002 → stp_lft=1, stp_rght=0, strt_mv pulse. A second cmd_rdy held during WAIT_MV gets no clr_cmd_rdy until one cycle after tx_done.
- Timeout (TIMEOUT=100): cmd=16'h0000, cal_done never → in_cal high, send_resp at cycle ~101 with resp=8'hEE, in_cal drops.
- Solve: cmd=16'h6000 → cmd_md=0 until sol_cmplt, then cmd_md=1, resp=8'hA5. Same-cycle sol_cmplt with watchdog==TIMEOUT → resp=8'hA5.
- Illegal: cmd=16'hE123 → clr_cmd_rdy, no start strobes, send_resp next cycle with resp=8'hE0. Assert rst during WAIT_TX → immediate IDLE.
